// File: rtl/psa_sub_serial.sv
// Serial sub-word saturating subtractor: four signed nibble lanes, one lane per
// clock through a shared carry-lookahead datapath, with a start/done handshake.
module psa_sub_serial #(
   parameter int NIB_W   = 4,
   parameter int NUM_NIB = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [NIB_W*NUM_NIB-1:0] A,
   input  logic [NIB_W*NUM_NIB-1:0] B,
   output logic                     busy,
   output logic                     done,
   output logic [NIB_W*NUM_NIB-1:0] Diff,
   output logic [NUM_NIB-1:0]       SatMask,
   output logic                     Error
);

   localparam int DW    = NIB_W * NUM_NIB;
   localparam int CNT_W = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]      a_q, a_d;
   logic [DW-1:0]      b_q, b_d;
   logic [DW-1:0]      acc_q, acc_d;
   logic [NUM_NIB-1:0] acc_sat_q, acc_sat_d;
   logic [DW-1:0]      diff_q, diff_d;
   logic [NUM_NIB-1:0] sat_q, sat_d;
   logic               err_q, err_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;

   logic [NIB_W-1:0]   lane_a, lane_b, lane_raw, lane_res;
   logic               lane_ovf;

   // Each carry is a flat sum of generate terms gated by the propagates above it.
   function automatic logic [NIB_W-1:0] cla_add(input logic [NIB_W-1:0] x,
                                                input logic [NIB_W-1:0] y,
                                                input logic             cin);
      logic [NIB_W-1:0] g, p, c;
      logic             term;
      g    = x & y;
      p    = x ^ y;
      c    = '0;
      c[0] = cin;
      for (int i = 0; i < NIB_W - 1; i++) begin
         term = cin;
         for (int k = 0; k <= i; k++) term = term & p[k];
         c[i+1] = term;
         for (int j = 0; j <= i; j++) begin
            term = g[j];
            for (int k = j + 1; k <= i; k++) term = term & p[k];
            c[i+1] = c[i+1] | term;
         end
      end
      return p ^ c;
   endfunction

   always_comb begin
      lane_a = '0;
      lane_b = '0;
      for (int i = 0; i < NUM_NIB; i++) begin
         if (cnt_q == CNT_W'(i)) begin
            lane_a = a_q[i*NIB_W +: NIB_W];
            lane_b = b_q[i*NIB_W +: NIB_W];
         end
      end
      lane_raw = cla_add(lane_a, ~lane_b, 1'b1);
      lane_ovf = (lane_a[NIB_W-1] != lane_b[NIB_W-1]) && (lane_raw[NIB_W-1] != lane_a[NIB_W-1]);
      if (!lane_ovf) begin
         lane_res = lane_raw;
      end else if (lane_a[NIB_W-1]) begin
         lane_res = {1'b1, {(NIB_W-1){1'b0}}};
      end else begin
         lane_res = {1'b0, {(NIB_W-1){1'b1}}};
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      acc_sat_d = acc_sat_q;
      diff_d    = diff_q;
      sat_d     = sat_q;
      err_d     = err_q;
      done_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d       = A;
               b_d       = B;
               acc_d     = '0;
               acc_sat_d = '0;
               cnt_d     = '0;
               state_d   = RUN;
            end
         end
         RUN: begin
            for (int i = 0; i < NUM_NIB; i++) begin
               if (cnt_q == CNT_W'(i)) begin
                  acc_d[i*NIB_W +: NIB_W] = lane_res;
                  acc_sat_d[i]            = lane_ovf;
               end
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(NUM_NIB - 1)) state_d = DONE;
         end
         DONE: begin
            diff_d  = acc_q;
            sat_d   = acc_sat_q;
            err_d   = |acc_sat_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         acc_sat_q <= '0;
         diff_q    <= '0;
         sat_q     <= '0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         acc_sat_q <= acc_sat_d;
         diff_q    <= diff_d;
         sat_q     <= sat_d;
         err_q     <= err_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign Diff    = diff_q;
   assign SatMask = sat_q;
   assign Error   = err_q;

endmodule

// File: doc/psa_sub_serial.md
Name: psa_sub_serial

Overview:
- Multi-cycle parallel sub-word saturating subtractor: the subtract direction of the 16-bit parallel sub-word adder.
- Treats each 16-bit operand as 4 independent signed 4-bit nibbles and computes Diff[i] = sat(A[i] - B[i]).
- Processes one nibble per clock through a single 4-bit datapath, nibble 0 (bits 3:0) first.
- Sits beside the ALU for multi-cycle sub-word ops; uses a start/done handshake with the execute-stage stall logic.

Parameters:
- NIB_W, 4, width of one sub-word lane in bits.
- NUM_NIB, 4, number of lanes; data width = NIB_W*NUM_NIB = 16.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- A  input  16  minuend; captured on accepted start.
- B  input  16  subtrahend; captured on accepted start.
- busy  output  1  high from the cycle after an accepted start through the last nibble cycle.
- done  output  1  one-cycle pulse when Diff, Error and SatMask are valid.
- Diff  output  16  packed per-nibble saturated differences.
- SatMask  output  4  bit i = nibble i saturated.
- Error  output  1  OR of SatMask.

Behaviour:
- Reset (rst=1 at a clock edge, any state including mid-operation):
  - State returns to IDLE; nibble counter = 0.
  - busy=0, done=0, Diff=16'h0000, SatMask=4'b0000, Error=0; captured operands cleared.
- States:
  - IDLE: start=1 captures A and B, clears the internal accumulators, sets counter=0 and moves to RUN.
  - RUN: each cycle computes nibble[counter] and writes it to the accumulator; counter increments. After nibble NUM_NIB-1 the state moves to DONE.
  - DONE: lasts exactly one cycle. done=1; Diff/SatMask/Error are loaded from the accumulators. The next state is IDLE.
- Latency:
  - Start accepted at edge 0; RUN occupies edges 1..4; done=1 in the cycle following edge 5.
  - Back-to-back throughput is one operation per 6 cycles (start is re-sampled once state is IDLE again).
- Output hold: Diff, SatMask and Error are updated only on DONE entry and held stable until the next DONE or reset. They are not modified during RUN.
- start while busy or DONE: ignored; no effect on the operation in flight.
- A/B changes after acceptance: no effect, because the operands are latched.
- Lane arithmetic:
  - Computed as a + ~b + 1 using a 4-bit carry-lookahead adder; no carry propagates between lanes.
  - Overflow when the sign of a differs from the sign of b and the sign of the raw result differs from the sign of a.
  - Positive overflow (a >= 0) saturates to 4'b0111 (+7); negative overflow saturates to 4'b1000 (-8).
  - Saturation sets SatMask[i].
- Boundary cases:
  - -8 - (+1) -> -8, saturated.
  - +7 - (-1) -> +7, saturated.
  - -8 - (-8) -> 0, not saturated.
  - x - x -> 0.
- busy is registered and is 0 in IDLE and DONE.

Test Plan:
- Basic: A=16'h1234, B=16'h1111, start pulsed 1 cycle -> busy high 4 cycles; done pulse 5 cycles after the start edge; Diff=16'h0123, SatMask=4'b0000, Error=0.
- Negative saturation: A=16'h8000, B=16'h1000 -> Diff=16'h8000, SatMask=4'b1000, Error=1. Then A=16'h8888, B=16'h8888 -> Diff=16'h0000, Error=0.
- Mixed lanes: A=16'h70F0, B=16'hF010 -> Diff=16'h70E0 (lane3 +7-(-1) saturates to 7; lane1 -1-1=-2), SatMask=4'b1000, Error=1.
- Protocol:
  - start held high continuously with A=16'h0001, B=16'h0001 -> done pulses every 6 cycles, Diff=16'h0000.
  - A/B changed to 16'hFFFF during RUN -> no effect on the result.
  - An extra start pulse during RUN -> ignored.
- Reset mid-operation: rst=1 on the 2nd RUN cycle of A=16'h7777, B=16'h9999 -> next cycle busy=0, done=0, Diff=0, Error=0; no done pulse follows. A subsequent start with A=16'h5555, B=16'h2222 yields Diff=16'h3333.
- All-lane saturation: A=16'h7777, B=16'h8888 -> Diff=16'h7777, SatMask=4'b1111, Error=1. Outputs are held unchanged for 10 idle cycles afterwards.
